// File: rtl/result_pkg.sv
// Shared constants, state encoding and sizing helper for the result collector
// that sits behind the sequential matrix multiplier.
package result_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Width that can hold every value from 0 up to and including n*n.
  function automatic int count_width(input int n);
    return $clog2(n * n + 1);
  endfunction

endpackage

// File: rtl/result_buffer.sv
// N x N element store with one synchronous write port and one asynchronous
// read port; the collector writes it and drains it in row-major order.
module result_buffer
  import result_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wi,
  input  logic [IW-1:0] wj,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] ri,
  input  logic [IW-1:0] rj,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [N][N];

  // NOTE: the data array has no reset; validity is tracked by the collector's
  // fill bitmap, so resetting it would only cost routing and reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[wi][wj] <= wdata;
  end

  assign rdata = mem[ri][rj];

endmodule

// File: rtl/result_collector.sv
// Collects strobed multiplier results into an N x N buffer, tracks filled
// cells, and drains the full matrix row-major over a valid/ready port.
module result_collector
  import result_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] z_out,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  input  logic          z_stb,
  output logic          z_ack,
  input  logic          clear,
  output logic          full,
  output logic          dup_err,
  input  logic          rd_start,
  output logic [DW-1:0] rd_value,
  output logic [IW-1:0] rd_i,
  output logic [IW-1:0] rd_j,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          done
);

  localparam int            CW    = count_width(N);
  localparam logic [CW-1:0] LAST  = CW'(N * N - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  state_e                 state;
  logic [N-1:0][N-1:0]    filled;
  logic [CW-1:0]          count;
  logic [DW-1:0]          buf_rdata;
  logic                   accept;
  logic                   beat;
  logic                   last_beat;

  // z_ack doubles as the "ignore z_stb" window, limiting accepts to one per
  // two cycles so the producer always sees the ack before re-strobing.
  assign accept    = (state == COLLECT) && z_stb && !z_ack && !clear;
  assign beat      = (state == DRAIN) && rd_valid && rd_ready;
  assign last_beat = (rd_i == IDX_MAX) && (rd_j == IDX_MAX);

  result_buffer #(.N(N), .DW(DW), .IW(IW)) u_buf (
    .clk   (clk),
    .we    (accept),
    .wi    (z_i),
    .wj    (z_j),
    .wdata (z_out),
    .ri    (rd_i),
    .rj    (rd_j),
    .rdata (buf_rdata)
  );

  // Gated so the port reads zero whenever no beat is being offered.
  assign rd_value = rd_valid ? buf_rdata : '0;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= COLLECT;
      filled   <= '0;
      count    <= '0;
      z_ack    <= 1'b0;
      full     <= 1'b0;
      dup_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_i     <= '0;
      rd_j     <= '0;
      done     <= 1'b0;
    end else if (clear) begin
      state    <= COLLECT;
      filled   <= '0;
      count    <= '0;
      z_ack    <= 1'b0;
      full     <= 1'b0;
      dup_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_i     <= '0;
      rd_j     <= '0;
      done     <= 1'b0;
    end else begin
      z_ack <= accept;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (filled[z_i][z_j]) begin
              dup_err <= 1'b1;
            end else begin
              filled[z_i][z_j] <= 1'b1;
              count            <= count + CW'(1);
              if (count == LAST) begin
                state <= FULL;
                full  <= 1'b1;
              end
            end
          end
        end
        FULL: begin
          if (rd_start) begin
            state    <= DRAIN;
            rd_valid <= 1'b1;
            rd_i     <= '0;
            rd_j     <= '0;
          end
        end
        DRAIN: begin
          if (beat) begin
            if (last_beat) begin
              state    <= DONE;
              rd_valid <= 1'b0;
              done     <= 1'b1;
              rd_i     <= '0;
              rd_j     <= '0;
            end else if (rd_j == IDX_MAX) begin
              rd_j <= '0;
              rd_i <= rd_i + IW'(1);
            end else begin
              rd_j <= rd_j + IW'(1);
            end
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: table-driven fill/drain vectors plus
// hand-written sequences for duplicates, clear, ignored rd_start and reset.
module tb_result_collector;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] z_out;
  logic [IW-1:0] z_i;
  logic [IW-1:0] z_j;
  logic          z_stb;
  logic          z_ack;
  logic          clear;
  logic          full;
  logic          dup_err;
  logic          rd_start;
  logic [DW-1:0] rd_value;
  logic [IW-1:0] rd_i;
  logic [IW-1:0] rd_j;
  logic          rd_valid;
  logic          rd_ready;
  logic          done;

  result_collector #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .z_out    (z_out),
    .z_i      (z_i),
    .z_j      (z_j),
    .z_stb    (z_stb),
    .z_ack    (z_ack),
    .clear    (clear),
    .full     (full),
    .dup_err  (dup_err),
    .rd_start (rd_start),
    .rd_value (rd_value),
    .rd_i     (rd_i),
    .rd_j     (rd_j),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [DW-1:0] wval;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs [16];
  logic [DW-1:0] exp_val [16];
  int            n_checks = 0;
  int            n_err    = 0;
  int            ack_cnt  = 0;
  int            ack_long = 0;
  logic          ack_prev = 1'b0;

  // Count z_ack pulses and flag any that last longer than one cycle.
  always @(negedge clk) begin
    if (z_ack) begin
      ack_cnt++;
      if (ack_prev) ack_long++;
    end
    ack_prev = z_ack;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic write_elem(input logic [IW-1:0] i, input logic [IW-1:0] j, input logic [DW-1:0] v);
    int k;
    z_i   = i;
    z_j   = j;
    z_out = v;
    z_stb = 1'b1;
    for (k = 0; k < 10; k++) begin
      tick();
      if (z_ack) break;
    end
    z_stb = 1'b0;
    if (k == 10) begin
      n_checks++;
      n_err++;
      $display("FAIL write_timeout: no z_ack for (%0d,%0d)", i, j);
    end
  endtask

  // mode 0: rd_ready always 1; mode 1: rd_ready pattern 1,0,0,1,0,0,...
  task automatic drain(input int mode, input string tag);
    int   beat = 0;
    int   cyc  = 0;
    logic rdy;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (beat < 16 && cyc < 200) begin
      check($sformatf("%s valid b%0d", tag, beat), rd_valid, 1);
      check($sformatf("%s value b%0d", tag, beat), rd_value, exp_val[beat]);
      check($sformatf("%s i b%0d", tag, beat), rd_i, beat / 4);
      check($sformatf("%s j b%0d", tag, beat), rd_j, beat % 4);
      rdy      = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      rd_ready = rdy;
      if (rdy) beat++;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    if (beat < 16) begin
      n_checks++;
      n_err++;
      $display("FAIL %s drain_timeout: beats %0d", tag, beat);
    end
    if (mode == 0) check($sformatf("%s cycles", tag), cyc, 16);
    check($sformatf("%s valid_end", tag), rd_valid, 0);
    check($sformatf("%s done", tag), done, 1);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      vecs[k].i    = IW'(k / 4);
      vecs[k].j    = IW'(k % 4);
      vecs[k].wval = DW'(100 + k);
      vecs[k].exp  = DW'(100 + k);
    end

    rst = 1'b0; z_stb = 1'b0; z_out = '0; z_i = '0; z_j = '0;
    clear = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    #1;
    check("rst z_ack", z_ack, 0);
    check("rst full", full, 0);
    check("rst done", done, 0);
    check("rst rd_valid", rd_valid, 0);
    #20 rst = 1'b1;
    tick();

    // Row-major fill
    ack_cnt = 0; ack_long = 0;
    for (int k = 0; k < 16; k++) begin
      write_elem(vecs[k].i, vecs[k].j, vecs[k].wval);
      if (k == 14) check("fill full_early", full, 0);
    end
    check("fill full", full, 1);
    check("fill dup_err", dup_err, 0);
    tick();
    check("fill ack_count", ack_cnt, 16);
    check("fill ack_long", ack_long, 0);

    // Reverse-order fill, free-running drain
    do_clear();
    check("clear full", full, 0);
    for (int k = 15; k >= 0; k--) write_elem(vecs[k].i, vecs[k].j, vecs[k].wval);
    for (int k = 0; k < 16; k++) exp_val[k] = vecs[k].exp;
    drain(0, "rev");

    // Backpressure
    do_clear();
    check("clear done", done, 0);
    for (int k = 0; k < 16; k++) write_elem(vecs[k].i, vecs[k].j, vecs[k].wval);
    drain(1, "bp");

    // Duplicate write
    do_clear();
    write_elem(2'd1, 2'd2, 32'd7);
    check("dup first", dup_err, 0);
    write_elem(2'd1, 2'd2, 32'd9);
    check("dup second", dup_err, 1);
    for (int k = 0; k < 16; k++) begin
      if (k != 6) begin
        if (k == 15) check("dup full_early", full, 0);
        write_elem(vecs[k].i, vecs[k].j, vecs[k].wval);
      end
    end
    check("dup full", full, 1);
    check("dup sticky", dup_err, 1);
    z_i = 2'd0; z_j = 2'd0; z_out = 32'd55; z_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("full no_ack %0d", k), z_ack, 0);
    end
    z_stb = 1'b0;
    for (int k = 0; k < 16; k++) exp_val[k] = vecs[k].exp;
    exp_val[6] = 32'd9;
    drain(0, "dup");

    // Control edges: ignored rd_start, clear racing a strobe
    do_clear();
    for (int k = 0; k < 10; k++) write_elem(vecs[k].i, vecs[k].j, vecs[k].wval);
    tick();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("early rd_start", rd_valid, 0);
    tick();
    check("early rd_start2", rd_valid, 0);
    z_i = vecs[10].i; z_j = vecs[10].j; z_out = vecs[10].wval;
    z_stb = 1'b1; clear = 1'b1;
    tick();
    check("clear stb no_ack", z_ack, 0);
    clear = 1'b0; z_stb = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      write_elem(vecs[k].i, vecs[k].j, vecs[k].wval);
      if (k == 14) check("restart full_early", full, 0);
    end
    check("restart full", full, 1);
    check("restart dup_err", dup_err, 0);

    // Asynchronous reset mid-drain, after five completed beats
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;
    check("pre_rst rd_i", rd_i, 1);
    check("pre_rst rd_j", rd_j, 1);
    #2 rst = 1'b0;
    #1;
    check("arst rd_valid", rd_valid, 0);
    check("arst rd_value", rd_value, 0);
    check("arst rd_i", rd_i, 0);
    check("arst rd_j", rd_j, 0);
    check("arst full", full, 0);
    check("arst done", done, 0);
    check("arst dup_err", dup_err, 0);
    check("arst z_ack", z_ack, 0);
    #10 rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
